// File: rtl/pipe_ctrl_pkg.sv
// pipe_pkg: shared FSM state, stage-control struct and width helpers for pipe_ctrl
package pipe_pkg;
  typedef enum logic [1:0] {RUN, DWAIT, ERR} state_t;
  typedef struct packed {logic en; logic clr;} stage_ctl_t;
  function automatic int md_w(int lat);
    return $clog2(lat + 1);
  endfunction
  function automatic int wd_w(int t);
    return $clog2(t);
  endfunction
  localparam int MD_W_DEF = md_w(32);
  localparam int WD_W_DEF = wd_w(255);
endpackage

// File: rtl/pipe_ctrl_if.sv
// pipe_ctrl_if: hazard requests in, stage enables/clears/status/perf counts out; master=hazard side, slave=pipe_ctrl
interface pipe_ctrl_if #(parameter int CNT_W = 32);
  logic StallF, StallD, FlushE, PCSrcD, MdStartE, HiLoReadD, DmemReqM, DmemReadyM;
  logic EnF, EnD, ClrD, EnE, ClrE, EnM, ClrW, MdBusy, BusErr;
  logic [CNT_W-1:0] StallCnt, FlushCnt;
  modport master(
    output StallF, StallD, FlushE, PCSrcD, MdStartE, HiLoReadD, DmemReqM, DmemReadyM,
    input  EnF, EnD, ClrD, EnE, ClrE, EnM, ClrW, MdBusy, BusErr, StallCnt, FlushCnt
  );
  modport slave(
    input  StallF, StallD, FlushE, PCSrcD, MdStartE, HiLoReadD, DmemReqM, DmemReadyM,
    output EnF, EnD, ClrD, EnE, ClrE, EnM, ClrW, MdBusy, BusErr, StallCnt, FlushCnt
  );
endinterface

// File: rtl/pipe_ctrl_wdog.sv
// pipe_ctrl_wdog: RUN/DWAIT/ERR data-memory wait FSM with watchdog; in clk, rst_n, i_req, i_ready; out o_freeze, o_bus_err
module pipe_ctrl_wdog import pipe_pkg::*; #(
  parameter int TIMEOUT = 255,
  parameter int WD_W = wd_w(TIMEOUT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_req,
  input  logic i_ready,
  output logic o_freeze,
  output logic o_bus_err
);
  state_t r_state, w_next;
  logic [WD_W-1:0] r_wd;
  logic w_wait, w_err;
  always_comb begin
    w_wait = i_req & ~i_ready;
    w_err = r_state == ERR;
    o_freeze = w_wait & ~w_err;
    o_bus_err = rst_n & w_err;
    w_next = r_state == RUN   ? (w_wait ? DWAIT : RUN) :
             r_state == DWAIT ? (!w_wait ? RUN : (r_wd == WD_W'(TIMEOUT - 1) ? ERR : DWAIT)) :
             ERR;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_wd <= '0;
    end else begin
      r_state <= w_next;
      r_wd <= (r_state == DWAIT && w_next == DWAIT) ? r_wd + 1'b1 : '0;
    end
  end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: resolves stall/flush/freeze/error into stage enables+clears, tracks mult/div busy; ports clk, rst_n, bus (pipe_ctrl_if.slave); PIPE_CTRL_PERF_EN adds StallCnt/FlushCnt
module pipe_ctrl import pipe_pkg::*; #(
  parameter int MD_LATENCY = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  pipe_ctrl_if.slave bus
);
  localparam int MDW = md_w(MD_LATENCY);
  logic [MDW-1:0] r_md;
  logic w_freeze, w_bus_err, w_md_busy, w_hs, w_halt, w_go;
  stage_ctl_t w_d, w_e;
  pipe_ctrl_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk(clk),
    .rst_n(rst_n),
    .i_req(bus.DmemReqM),
    .i_ready(bus.DmemReadyM),
    .o_freeze(w_freeze),
    .o_bus_err(w_bus_err)
  );
  always_comb begin
    w_md_busy = r_md != '0;
    w_hs = bus.StallF | bus.StallD | bus.FlushE | (bus.HiLoReadD & w_md_busy);
    w_halt = w_freeze | w_bus_err;
    w_go = rst_n & ~w_halt & ~w_hs;
    w_d = '{en: w_go, clr: ~rst_n | (w_go & bus.PCSrcD)};
    w_e = '{en: rst_n & ~w_halt, clr: ~rst_n | (~w_halt & w_hs)};
  end
  assign bus.EnF = w_go;
  assign bus.EnD = w_d.en;
  assign bus.ClrD = w_d.clr;
  assign bus.EnE = w_e.en;
  assign bus.ClrE = w_e.clr;
  assign bus.EnM = w_e.en;
  assign bus.ClrW = ~rst_n | w_halt;
  assign bus.MdBusy = rst_n & w_md_busy;
  assign bus.BusErr = w_bus_err;
  always_ff @(posedge clk) begin
    if (!rst_n) r_md <= '0;
    else if (bus.MdStartE & ~w_freeze & ~w_bus_err) r_md <= MDW'(MD_LATENCY);
    else if (w_md_busy) r_md <= r_md - 1'b1;
  end
`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_freeze | w_hs) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_d.clr | w_e.clr) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end
  assign bus.StallCnt = r_stall_cnt;
  assign bus.FlushCnt = r_flush_cnt;
`else
  assign bus.StallCnt = '0;
  assign bus.FlushCnt = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl (MD_LATENCY=4, TIMEOUT=8)
module tb_pipe_ctrl;
  localparam logic [8:0] V_RUN = 9'b110101000;
  localparam logic [8:0] V_RST = 9'b001010100;
  localparam logic [8:0] V_HS  = 9'b000111000;
  localparam logic [8:0] V_BR  = 9'b111101000;
  localparam logic [8:0] V_FRZ = 9'b000000100;
  localparam logic [8:0] V_ERR = 9'b000000101;
  localparam logic [8:0] V_MD  = 9'b000000010;
  logic clk = 1'b0;
  logic rst_n;
  int n_checks = 0;
  int n_errors = 0;
  pipe_ctrl_if #(.CNT_W(32)) bus();
  pipe_ctrl #(.MD_LATENCY(4), .TIMEOUT(8), .CNT_W(32)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  function automatic logic [8:0] outs();
    return {bus.EnF, bus.EnD, bus.ClrD, bus.EnE, bus.ClrE, bus.EnM, bus.ClrW, bus.MdBusy, bus.BusErr};
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [7:0] v);
    {bus.StallF, bus.StallD, bus.FlushE, bus.PCSrcD, bus.MdStartE, bus.HiLoReadD, bus.DmemReqM, bus.DmemReadyM} = v;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst_n = 1'b0;
    drive(8'h00);
    #2 check("rst", outs(), V_RST);
    tick();
    tick();
    rst_n = 1'b1;
    #1 check("run", outs(), V_RUN);
    check("rst_stall_cnt", bus.StallCnt, 0);
    drive(8'b1110_0000);
    #1 check("hs", outs(), V_HS);
    tick();
    drive(8'h00);
    #1 check("hs_rel", outs(), V_RUN);
    tick();
    drive(8'b0101_0010);
    for (int i = 0; i < 3; i++) begin
      #1 check("frz", outs(), V_FRZ);
      tick();
    end
    drive(8'b0101_0011);
    #1 check("frz_rel", outs(), V_HS);
    tick();
    drive(8'h00);
    tick();
    drive(8'b0001_0000);
    #1 check("br", outs(), V_BR);
    tick();
    drive(8'b0000_1000);
    #1 check("md_start", outs(), V_RUN);
    tick();
    drive(8'b0000_0100);
    for (int i = 0; i < 4; i++) begin
      #1 check("md_wait", outs(), V_HS | V_MD);
      tick();
    end
    #1 check("md_done", outs(), V_RUN);
    drive(8'b0000_1000);
    tick();
    drive(8'h00);
    tick();
    tick();
    drive(8'b0000_1000);
    #1 check("md_cnt2", outs(), V_RUN | V_MD);
    tick();
    drive(8'h00);
    for (int i = 0; i < 4; i++) begin
      #1 check("md_reload", outs(), V_RUN | V_MD);
      tick();
    end
    #1 check("md_reload_done", outs(), V_RUN);
    drive(8'b0000_1010);
    #1 check("frz_md", outs(), V_FRZ);
    tick();
    drive(8'h00);
    #1 check("frz_md_drop", outs(), V_RUN);
    tick();
    drive(8'b0000_0010);
    for (int i = 0; i < 9; i++) begin
      #1 check("wd_wait", outs(), V_FRZ);
      tick();
    end
    #1 check("err", outs(), V_ERR);
    drive(8'b0000_0011);
    #1 check("err_rdy", outs(), V_ERR);
    tick();
    #1 check("err_hold", outs(), V_ERR);
    rst_n = 1'b0;
    #1 check("err_rst", outs(), V_RST);
    tick();
    rst_n = 1'b1;
    drive(8'h00);
    #1 check("err_clr", outs(), V_RUN);
    tick();
    drive(8'b1000_0000);
    tick();
    tick();
    drive(8'b0001_0000);
    tick();
    drive(8'h00);
    #1;
`ifdef PIPE_CTRL_PERF_EN
    check("stall_cnt", bus.StallCnt, 2);
    check("flush_cnt", bus.FlushCnt, 3);
`else
    check("stall_cnt", bus.StallCnt, 0);
    check("flush_cnt", bus.FlushCnt, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Consumer side of the hazard-detection interface for the 5-stage MIPS pipeline.
- Takes the hazard unit's stall/flush requests (StallF, StallD, FlushE), the branch-taken signal, data-memory wait and the multiply/divide busy window.
- Resolves them by priority into per-stage register enables and clears (F, D, E, M, W).
- Owns the sequential pieces: data-memory wait FSM with watchdog, and a HI/LO busy counter for the iterative mult/div unit.

Parameters:
- MD_LATENCY, 32, cycles HI/LO stay busy after a mult/div is accepted (1..255).
- TIMEOUT, 255, maximum consecutive data-memory wait cycles before bus error (2..65535).
- CNT_W, 32, width of performance counters.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  synchronous reset, active-low
- StallF  in  1  from hazard unit
- StallD  in  1  from hazard unit
- FlushE  in  1  from hazard unit
- PCSrcD  in  1  branch taken, resolved in D
- MdStartE  in  1  mult/div instruction in E
- HiLoReadD  in  1  mfhi/mflo in D
- DmemReqM  in  1  load/store in M
- DmemReadyM  in  1  data memory ready
- EnF  out  1  PC enable
- EnD  out  1  IF/ID enable
- ClrD  out  1  IF/ID clear
- EnE  out  1  ID/EX enable
- ClrE  out  1  ID/EX clear
- EnM  out  1  EX/MEM enable
- ClrW  out  1  MEM/WB clear (bubble)
- MdBusy  out  1  HI/LO result pending
- BusErr  out  1  sticky watchdog error
- StallCnt  out  CNT_W  stall cycles (optional)
- FlushCnt  out  CNT_W  flush events (optional)

Behaviour:
- One clock (clk). Reset is synchronous, active-low (rst_n).
- While rst_n=0:
  - Enables EnF, EnD, EnE, EnM = 0; clears ClrD, ClrE, ClrW = 1.
  - MdBusy = 0, BusErr = 0.
  - FSM = RUN; md counter, watchdog and perf counters = 0.
- Outputs are combinational from inputs and registered state, taking effect in the same cycle.
- Freeze = DmemReqM & ~DmemReadyM, state ≠ ERR.
- Priority, highest first:
  1. ERR: all enables 0, ClrW=1, ClrD=ClrE=0; pipeline halted until reset.
  2. Freeze: EnF=EnD=EnE=EnM=0, ClrW=1, ClrD=ClrE=0. StallF/StallD/FlushE/PCSrcD are ignored; they are re-evaluated once the pipeline moves.
  3. Hazard stall, where Hs = StallF | StallD | FlushE | (HiLoReadD & MdBusy): EnF=EnD=0, ClrE=1, EnE=EnM=1, ClrD=0.
  4. PCSrcD alone: ClrD=1; all enables 1.
  5. Otherwise: all enables 1, all clears 0.
- ClrD is never asserted in the same cycle as EnD=0.
- FSM states: RUN, DWAIT, ERR.
  - RUN→DWAIT on Freeze; watchdog is cleared.
  - DWAIT→RUN when DmemReadyM=1 or DmemReqM=0.
  - DWAIT: watchdog increments each cycle. When watchdog = TIMEOUT−1 and still waiting → ERR.
  - ERR is absorbing until rst_n=0; BusErr=1 while in ERR.
- Mult/div counter:
  - MdStartE & ~Freeze & state≠ERR loads MD_LATENCY. This also applies when already busy (restart; no accumulation).
  - Otherwise the counter decrements when nonzero, every cycle including Freeze cycles, because the unit runs independently.
  - MdBusy = (counter ≠ 0). MdStartE is not accepted during Freeze because the E instruction is held and will be re-seen.
- Reset mid-operation:
  - Counter, watchdog and FSM clear on the next edge with rst_n=0.
  - A pending mult/div is dropped.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- When defined, StallCnt and FlushCnt are present:
  - StallCnt increments each cycle with Freeze or Hs.
  - FlushCnt increments each cycle with ClrD=1 or (ClrE=1 and not in reset).
  - Both wrap modulo 2^CNT_W and clear on reset.
- When undefined, the ports are tied to 0 and no counter flops are synthesized.

Decomposition:
- Shared package pipe_pkg:
  - FSM state enum (RUN, DWAIT, ERR).
  - Stage-control struct {en, clr}.
  - Localparams for the md counter width ($clog2(MD_LATENCY+1)) and watchdog width ($clog2(TIMEOUT)).
- One natural sub-module: pipe_ctrl_wdog, containing the DWAIT/ERR FSM and watchdog counter; outputs Freeze and BusErr.

Test Plan:
- Reset release, all hazard inputs 0 → EnF=EnD=EnE=EnM=1, all clears 0, MdBusy=0.
- StallF=StallD=FlushE=1 for 1 cycle → EnF=EnD=0, ClrE=1, EnM=1; next cycle all enables 1.
- DmemReqM=1, DmemReadyM=0 for 3 cycles with StallD=1 and PCSrcD=1 → frozen 3 cycles (ClrW=1, ClrD=ClrE=0); ready on cycle 4 → hazard path active.
- MD_LATENCY=4: MdStartE pulse, then HiLoReadD=1 held → EnF=EnD=0 for exactly 4 cycles; MdBusy falls on the 4th edge; second MdStartE at count 2 reloads to 4.
- TIMEOUT=8, DmemReadyM held 0 → ERR after 8 wait cycles; BusErr=1, all enables 0; DmemReadyM=1 does not recover; rst_n=0 for 1 cycle clears.
- With PIPE_CTRL_PERF_EN: 2 stall cycles + 1 branch flush → StallCnt=2, FlushCnt=3 (2 ClrE + 1 ClrD); undefined → both read 0.
